// File: rtl/uart_pkg.sv
// Encodings shared between the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and data-bit counter for the UART transmitter.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             cnt_en,
  input  logic [width-1:0] load_data,
  output logic             ser_data,
  output logic             ser_done
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  logic [width-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
    end else begin
      if (shift_en) shreg <= shreg >> 1;
      // saturate on the last bit so the count never wraps inside a frame
      if (cnt_en && !ser_done) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign ser_data = shreg[0];
  assign ser_done = (bit_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
//   state  | meaning
//   IDLE   | line idle high, ready for a word
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | parity bit
//   STOP   | stop bit; a new word may be accepted here
module uart_tx
  import uart_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);

  uart_state_t state, state_nxt;
  logic accept;
  logic par_en_q, par_bit_q;
  logic tx_nxt, busy_nxt;
  logic ser_data, ser_done;

  assign accept = Data_Valid && (state == IDLE || state == STOP);

  // The register starts shifting in START so that ser_data always holds
  // the bit for the next cycle, keeping TX_OUT a clean registered output.
  uart_tx_serializer #(.width(width)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift_en  (state == START || state == DATA),
    .cnt_en    (state == DATA),
    .load_data (P_DATA),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      Busy   <= busy_nxt;
      if (accept) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Data_Valid) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (ser_done) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = Data_Valid ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = ser_data;
      PARITY:  tx_nxt = par_bit_q;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: queue-based line model plus literal frame checks.
module tb_uart_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         Busy;

  int vectors = 0;
  int miscompares = 0;

  uart_tx #(.width(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Line model: the bits still to be sent after the current cycle. A word is
  // accepted when nothing is queued (line idle, or on its final stop bit).
  logic exp_q[$];
  logic cur_tx = 1'b1;
  logic cur_busy = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur_tx   = 1'b1;
      cur_busy = 1'b0;
    end else begin
      if (Data_Valid && exp_q.size() == 0) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_q.push_back(P_DATA[i]);
        if (PAR_EN) exp_q.push_back((^P_DATA) ^ PAR_TYP);
        exp_q.push_back(1'b1);
      end
      if (exp_q.size() > 0) begin
        cur_tx   = exp_q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_tx   = 1'b1;
        cur_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_tx", {31'd0, TX_OUT}, {31'd0, cur_tx});
    chk("model_busy", {31'd0, Busy}, {31'd0, cur_busy});
  end

  // Returns one cycle after the accepting edge, i.e. inside the start bit.
  task automatic send(input logic [W-1:0] d, input logic pen, input logic ptyp);
    @(posedge clk); #1;
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(posedge clk); #1;
    Data_Valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] tx, output logic [31:0] bz);
    tx = '0;
    bz = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx[i] = TX_OUT;
      bz[i] = Busy;
    end
  endtask

  logic [31:0] tx_cap, bz_cap;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_tx", {31'd0, TX_OUT}, 32'd1);
      chk("idle_busy", {31'd0, Busy}, 32'd0);
    end

    send(8'hA5, 1'b0, 1'b0);
    capture(11, tx_cap, bz_cap);
    chk("a5_nopar_tx", tx_cap, 32'h74A);
    chk("a5_nopar_busy", bz_cap, 32'h3FF);

    send(8'hA5, 1'b1, 1'b0);
    capture(12, tx_cap, bz_cap);
    chk("a5_even_tx", tx_cap, 32'hD4A);
    chk("a5_even_busy", bz_cap, 32'h7FF);

    send(8'hA5, 1'b1, 1'b1);
    capture(12, tx_cap, bz_cap);
    chk("a5_odd_tx", tx_cap, 32'hF4A);

    send(8'h01, 1'b1, 1'b0);
    capture(12, tx_cap, bz_cap);
    chk("01_even_tx", tx_cap, 32'hE02);
    chk("01_even_busy", bz_cap, 32'h7FF);

    // second word offered during the stop bit of the first
    send(8'h00, 1'b0, 1'b0);
    fork
      capture(21, tx_cap, bz_cap);
      begin
        repeat (9) @(posedge clk);
        #1;
        P_DATA = 8'hFF; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0;
      end
    join
    chk("b2b_tx", tx_cap, 32'h1FFA00);
    chk("b2b_busy", bz_cap, 32'hFFFFF);

    // new request and data change during DATA must not disturb the frame
    send(8'hA5, 1'b0, 1'b0);
    fork
      capture(11, tx_cap, bz_cap);
      begin
        repeat (3) @(posedge clk);
        #1;
        P_DATA = 8'h3C; Data_Valid = 1'b1; PAR_EN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Data_Valid = 1'b0; PAR_EN = 1'b0;
      end
    join
    chk("ignore_tx", tx_cap, 32'h74A);
    chk("ignore_busy", bz_cap, 32'h3FF);

    // reset in the middle of the third data bit
    send(8'hA5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, TX_OUT}, 32'd1);
    chk("rst_async_busy", {31'd0, Busy}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    send(8'h3C, 1'b0, 1'b0);
    capture(11, tx_cap, bz_cap);
    chk("post_rst_tx", tx_cap, 32'h678);
    chk("post_rst_busy", bz_cap, 32'h3FF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
